uart_rx_core: RTL
=================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter OVS, default 16, meaning oversample ticks per bit; legal values are even numbers 8..32.
REQ-002 Parameter DMAX, default 9, meaning maximum data bits per frame, which is also the width of rx_data.
REQ-003 Parameter TOC_CHARS, default 4, meaning idle character times before rx_timeout fires.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port wb_rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port enable, input, 1 bit: oversample tick; the FSM and counters advance only in cycles where it is high.
REQ-007 Port srx_pad_i, input, 1 bit: asynchronous serial line; idle level is 1.
REQ-008 Port cfg_len, input, 3 bits: data bits minus 5, so 0..4 select 5..9 bits; values above DMAX-5 saturate to DMAX.
REQ-009 Port cfg_pe / cfg_ep / cfg_sp, input, 1 bit each: parity enable, even parity, stick parity.
REQ-010 Port cfg_stb, input, 1 bit: 0 selects one stop bit, 1 selects two.
REQ-011 Port rx_data, output, DMAX bits: received data, LSB-first on the line, right-aligned, unused MSBs 0.
REQ-012 Port rx_perr / rx_ferr / rx_brk, output, 1 bit each: parity error, framing error and break status for rx_data.
REQ-013 Port rx_valid, output, 1 bit / rx_ready, input, 1 bit: output handshake; transfer occurs when both are high.
REQ-014 Port rx_overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.
REQ-015 Port rx_timeout, output, 1 bit: one-cycle pulse on an idle timeout.
REQ-016 Port rx_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-017 srx_pad_i SHALL pass through a 2-flop synchroniser; every later reference to the line means the synchronised value rx_s.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BRKWAIT.
REQ-019 IDLE SHALL move to START on the first enable tick with rx_s=0, clear the tick counter, and latch cfg_*; cfg changes mid-frame SHALL be ignored.
REQ-020 Each bit SHALL be resolved as the majority vote of rx_s at ticks OVS/2-1, OVS/2 and OVS/2+1 of its bit period; the bit period ends at tick OVS-1.
REQ-021 In START, a voted 1 SHALL return the FSM to IDLE as a glitch, with no output and no error.
REQ-022 DATA SHALL shift in exactly the latched length of bits, LSB first.
REQ-023 PARITY SHALL be visited only when pe=1.
REQ-024 Parity error rules (sp, ep): 00 odd, 01 even, 10 parity bit must be 1, 11 parity bit must be 0.
REQ-025 STOP SHALL check one or two stop bits; any voted 0 SHALL set ferr.
REQ-026 The frame SHALL complete at the middle vote of the last stop bit, not at the end of its period.
REQ-027 Break: if every voted bit of the frame, start through last stop, is 0, the completed word SHALL be data=0, brk=1, ferr=1, perr=0, and the FSM SHALL enter BRKWAIT.
REQ-028 BRKWAIT SHALL return to IDLE after rx_s=1 on an enable tick.
REQ-029 On completion with rx_valid=0, or with rx_valid=1 and rx_ready=1 in the same cycle, the word SHALL load into the output registers and rx_valid SHALL be 1 from the next cycle.
REQ-030 On completion with rx_valid=1 and rx_ready=0, the new word SHALL be dropped, the held word kept, and rx_overrun pulsed for one cycle.
REQ-031 rx_valid SHALL fall the cycle after a transfer unless a new word loads in that same cycle.
REQ-032 Timeout counter: reload value is TOC_CHARS*(1+len+pe+stop bits)*OVS ticks.
REQ-033 The timeout counter SHALL reload on start detection, on transfer, and on every cycle where rx_valid=0.
REQ-034 The timeout counter SHALL decrement on enable ticks; on reaching 0 it SHALL pulse rx_timeout once and hold at 0 until reloaded.
REQ-035 Latency from the last stop-bit middle vote to rx_valid=1 SHALL be 1 clk.

Reset
REQ-036 While wb_rst_ni=0 at a clk edge: FSM IDLE, synchroniser flops 1, rx_data 0, rx_perr/rx_ferr/rx_brk 0, rx_valid 0, rx_overrun 0, rx_timeout 0, rx_busy 0, timeout counter at reload value.
REQ-037 Reset mid-frame SHALL abort the frame with no output; reset with rx_valid=1 SHALL discard the held word.

Structure
REQ-038 Package uart_rx_pkg SHALL hold the FSM state encoding, the parity-mode encoding, and the functions for frame length and timeout counter width.
REQ-039 Sub-module uart_rx_vote SHALL implement the synchroniser plus the 3-sample majority vote; everything else stays in uart_rx_core.

Verification
REQ-040 Scenario 8N1, OVS=16, byte 0xA5, rx_ready=1: rx_data=0x0A5, all errors 0, rx_valid for 1 cycle.
REQ-041 Scenario 9E2, data 0x1FF, correct parity, then the same frame with parity flipped: first perr=0, second perr=1, ferr=0 for both.
REQ-042 Scenario start bit low for 6 ticks then high: no rx_valid, FSM back in IDLE, rx_busy low.
REQ-043 Scenario line held 0 for 2 frame times, then released: one word with data 0, brk=1, ferr=1; FSM in IDLE only after release.
REQ-044 Scenario two frames with rx_ready=0: first word held, rx_overrun pulses once at the second completion, data still the first byte.
REQ-045 Scenario 8N1, TOC_CHARS=4, one word pending with no ready: rx_timeout pulses once after 640 ticks and does not repeat.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver.
//   rx_state_e  : receiver FSM state encoding
//   par_mode_e  : parity mode, encoded as {stick, even}
//   frame_bits  : line bits in one character (start + data + parity + stop)
//   toc_width   : width of the idle-timeout counter for the widest frame
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRKWAIT
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_ODD   = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_MARK  = 2'b10,  // parity bit must be 1
    PAR_SPACE = 2'b11   // parity bit must be 0
  } par_mode_e;

  function automatic int unsigned frame_bits(int unsigned data_bits,
                                             int unsigned pe,
                                             int unsigned stb);
    return 1 + data_bits + pe + ((stb != 0) ? 2 : 1);
  endfunction

  function automatic int unsigned toc_width(int unsigned toc_chars,
                                            int unsigned dmax,
                                            int unsigned ovs);
    return $clog2(toc_chars * frame_bits(dmax, 1, 1) * ovs + 1);
  endfunction

endpackage

// File: rtl/uart_rx_vote.sv
// Line front end: 2-flop synchroniser and 3-sample majority vote.
//   clk, wb_rst_ni : clock, synchronous active-low reset
//   i_enable       : oversample tick
//   i_srx          : raw asynchronous serial line
//   i_tick         : tick index within the current bit period
//   o_rx_s         : synchronised line
//   o_vote_valid   : high on the tick that resolves the bit (OVS/2+1)
//   o_vote         : majority of rx_s at ticks OVS/2-1, OVS/2, OVS/2+1
module uart_rx_vote
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVS = 16,
  parameter int unsigned TW  = $clog2(OVS)
) (
  input  logic          clk,
  input  logic          wb_rst_ni,
  input  logic          i_enable,
  input  logic          i_srx,
  input  logic [TW-1:0] i_tick,
  output logic          o_rx_s,
  output logic          o_vote_valid,
  output logic          o_vote
);

  localparam logic [TW-1:0] TICK_A = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TICK_B = TW'(OVS / 2);
  localparam logic [TW-1:0] TICK_C = TW'(OVS / 2 + 1);

  logic r_sync1;
  logic r_rx_s;
  logic r_samp_a;
  logic r_samp_b;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values; blocking here would collapse the synchroniser.
  always_ff @(posedge clk) begin
    if (!wb_rst_ni) begin
      r_sync1  <= 1'b1;
      r_rx_s   <= 1'b1;
      r_samp_a <= 1'b1;
      r_samp_b <= 1'b1;
    end else begin
      r_sync1 <= i_srx;
      r_rx_s  <= r_sync1;
      if (i_enable && i_tick == TICK_A) r_samp_a <= r_rx_s;
      if (i_enable && i_tick == TICK_B) r_samp_b <= r_rx_s;
    end
  end

  // The third sample is the live rx_s, so the vote resolves on tick C itself.
  assign o_rx_s       = r_rx_s;
  assign o_vote_valid = i_enable && (i_tick == TICK_C);
  assign o_vote       = (r_samp_a & r_samp_b) | (r_samp_a & r_rx_s) | (r_samp_b & r_rx_s);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core: frame FSM, data/parity/stop checking, break detect,
// output holding register with valid/ready handshake, idle timeout.
//   clk, wb_rst_ni          : clock, synchronous active-low reset
//   enable                  : oversample tick (OVS per bit)
//   srx_pad_i               : asynchronous serial input, idle high
//   cfg_len/pe/ep/sp/stb    : frame format, latched at start detection
//   rx_data, rx_perr/ferr/brk, rx_valid, rx_ready : received word + handshake
//   rx_overrun, rx_timeout  : one-cycle event pulses
//   rx_busy                 : FSM not idle
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVS       = 16,
  parameter int unsigned DMAX      = 9,
  parameter int unsigned TOC_CHARS = 4
) (
  input  logic            clk,
  input  logic            wb_rst_ni,
  input  logic            enable,
  input  logic            srx_pad_i,
  input  logic [2:0]      cfg_len,
  input  logic            cfg_pe,
  input  logic            cfg_ep,
  input  logic            cfg_sp,
  input  logic            cfg_stb,
  output logic [DMAX-1:0] rx_data,
  output logic            rx_perr,
  output logic            rx_ferr,
  output logic            rx_brk,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            rx_overrun,
  output logic            rx_timeout,
  output logic            rx_busy
);

  localparam int unsigned TICK_W = $clog2(OVS);
  localparam int unsigned LEN_W  = $clog2(DMAX + 1);
  localparam int unsigned TOC_W  = toc_width(TOC_CHARS, DMAX, OVS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS - 1);
  // Latched format after reset is DMAX data bits, no parity, one stop bit.
  localparam logic [TOC_W-1:0]  TOC_RST   = TOC_W'(TOC_CHARS * frame_bits(DMAX, 0, 0) * OVS);

  rx_state_e         r_state, w_next_state;
  logic [TICK_W-1:0] r_tick;
  logic [LEN_W-1:0]  r_bit_cnt;
  logic [LEN_W-1:0]  r_len;
  logic              r_pe, r_stb;
  par_mode_e         r_pmode;
  logic [DMAX-1:0]   r_shift;
  logic              r_par, r_perr_f, r_ferr_f, r_all0;
  logic [DMAX-1:0]   r_data;
  logic              r_perr, r_ferr, r_brk, r_valid, r_overrun, r_timeout;
  logic [TOC_W-1:0]  r_toc;

  logic              w_rx_s, w_vote_valid, w_vote;
  logic              w_period_end, w_last_stop, w_in_frame;
  logic              w_start_det, w_complete, w_brk_word;
  logic              w_xfer, w_toc_load;
  logic [LEN_W-1:0]  w_cfg_bits;
  logic [TOC_W-1:0]  w_toc_reload;

  function automatic logic parity_bad(par_mode_e mode, logic data_xor, logic pbit);
    case (mode)
      PAR_ODD:  return ~(data_xor ^ pbit);
      PAR_EVEN: return data_xor ^ pbit;
      PAR_MARK: return ~pbit;
      default:  return pbit;
    endcase
  endfunction

  uart_rx_vote #(.OVS(OVS), .TW(TICK_W)) u_vote (
    .clk          (clk),
    .wb_rst_ni    (wb_rst_ni),
    .i_enable     (enable),
    .i_srx        (srx_pad_i),
    .i_tick       (r_tick),
    .o_rx_s       (w_rx_s),
    .o_vote_valid (w_vote_valid),
    .o_vote       (w_vote)
  );

  // Oversized cfg_len values saturate to DMAX data bits.
  assign w_cfg_bits   = LEN_W'(((32'(cfg_len) + 32'd5) > DMAX) ? DMAX : (32'(cfg_len) + 32'd5));
  assign w_in_frame   = r_state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
  assign w_period_end = enable && (r_tick == TICK_LAST);
  assign w_last_stop  = (r_bit_cnt == LEN_W'(r_stb));
  assign w_xfer       = r_valid && rx_ready;
  assign w_toc_load   = w_start_det || w_xfer || !r_valid;
  assign w_toc_reload = TOC_W'(TOC_CHARS * frame_bits(32'(r_len), 32'(r_pe), 32'(r_stb)) * OVS);

  always_ff @(posedge clk) begin
    if (!wb_rst_ni) r_state <= ST_IDLE;
    else            r_state <= w_next_state;
  end

  // NOTE: every signal driven here gets a default before the case, otherwise
  // paths that skip an assignment would infer latches.
  always_comb begin
    w_next_state = r_state;
    w_start_det  = 1'b0;
    w_complete   = 1'b0;
    w_brk_word   = 1'b0;
    case (r_state)
      ST_IDLE: if (enable && !w_rx_s) begin
        w_next_state = ST_START;
        w_start_det  = 1'b1;
      end
      ST_START: begin
        if (w_vote_valid && w_vote) w_next_state = ST_IDLE;  // glitch
        else if (w_period_end)      w_next_state = ST_DATA;
      end
      ST_DATA: if (w_period_end && r_bit_cnt == r_len)
        w_next_state = r_pe ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_period_end) w_next_state = ST_STOP;
      ST_STOP: if (w_vote_valid && w_last_stop) begin
        w_complete   = 1'b1;
        w_brk_word   = r_all0 && !w_vote;
        w_next_state = w_brk_word ? ST_BRKWAIT : ST_IDLE;
      end
      ST_BRKWAIT: if (enable && w_rx_s) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Frame datapath. r_bit_cnt counts data bits in DATA and stop bits in STOP.
  // NOTE: r_shift has no reset; it is cleared at every start detection and
  // only reaches the outputs through a completed frame.
  always_ff @(posedge clk) begin
    if (!wb_rst_ni) begin
      r_tick    <= '0;
      r_bit_cnt <= '0;
      r_len     <= LEN_W'(DMAX);
      r_pe      <= 1'b0;
      r_stb     <= 1'b0;
      r_pmode   <= PAR_ODD;
      r_par     <= 1'b0;
      r_perr_f  <= 1'b0;
      r_ferr_f  <= 1'b0;
      r_all0    <= 1'b1;
    end else if (w_start_det) begin
      r_tick    <= '0;
      r_bit_cnt <= '0;
      r_len     <= w_cfg_bits;
      r_pe      <= cfg_pe;
      r_stb     <= cfg_stb;
      r_pmode   <= par_mode_e'({cfg_sp, cfg_ep});
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_perr_f  <= 1'b0;
      r_ferr_f  <= 1'b0;
      r_all0    <= 1'b1;
    end else if (w_in_frame) begin
      if (enable) r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + TICK_W'(1);
      if (w_vote_valid) begin
        if (w_vote) r_all0 <= 1'b0;
        case (r_state)
          ST_DATA: begin
            r_shift[r_bit_cnt] <= w_vote;
            r_par              <= r_par ^ w_vote;
            r_bit_cnt          <= r_bit_cnt + LEN_W'(1);
          end
          ST_PARITY: r_perr_f <= parity_bad(r_pmode, r_par, w_vote);
          ST_STOP: begin
            if (!w_vote)      r_ferr_f  <= 1'b1;
            if (!w_last_stop) r_bit_cnt <= r_bit_cnt + LEN_W'(1);
          end
          default: ;
        endcase
      end
      if (r_state == ST_DATA && w_period_end && r_bit_cnt == r_len) r_bit_cnt <= '0;
    end
  end

  // Output holding register, handshake and timeout.
  always_ff @(posedge clk) begin
    if (!wb_rst_ni) begin
      r_data     <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_brk      <= 1'b0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
      r_toc      <= TOC_RST;
    end else begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      if (w_complete && (!r_valid || rx_ready)) begin
        r_data  <= w_brk_word ? '0 : r_shift;
        r_perr  <= w_brk_word ? 1'b0 : r_perr_f;
        r_ferr  <= r_ferr_f || !w_vote;
        r_brk   <= w_brk_word;
        r_valid <= 1'b1;
      end else begin
        if (w_complete) r_overrun <= 1'b1;
        if (w_xfer)     r_valid   <= 1'b0;
      end
      if (w_toc_load) begin
        r_toc <= w_toc_reload;
      end else if (enable && r_toc != '0) begin
        r_toc <= r_toc - TOC_W'(1);
        if (r_toc == TOC_W'(1)) r_timeout <= 1'b1;
      end
    end
  end

  assign rx_data    = r_data;
  assign rx_perr    = r_perr;
  assign rx_ferr    = r_ferr;
  assign rx_brk     = r_brk;
  assign rx_valid   = r_valid;
  assign rx_overrun = r_overrun;
  assign rx_timeout = r_timeout;
  assign rx_busy    = (r_state != ST_IDLE);

endmodule
